trap_commit: RTL

Consumes the trap/mode-change decision from the privilege stage and commits it architecturally. On a trap it writes mepc, mcause and mstatus through the CSR write port in three sequential cycles, then issues a one-cycle pipeline flush and redirect to the trap vector. On a mode change (mret) it restores mstatus, switches the privilege mode and redirects to mepc. It sits directly downstream of the privilege stage and upstream of the CSR file and fetch redirect logic.

---
 rtl/trap_commit.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/trap_commit.sv
// Commits trap and mret decisions from the privilege stage: sequences the mepc/mcause/mstatus
// CSR writes, then issues a single-cycle flush and fetch redirect, and tracks the privilege mode.
module trap_commit #(
    parameter logic [1:0] MODE_RESET = 2'b11
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MMU_WAIT,
    input  logic        TRAP_EN,
    input  logic [31:0] TRAP_PC,
    input  logic [31:0] TRAP_CODE,
    input  logic [31:0] TRAP_JMP_TO,
    input  logic        CHMODE_DO,
    input  logic [1:0]  CHMODE_TO,
    input  logic [31:0] MSTATUS,
    input  logic [31:0] MEPC,
    output logic        CSR_W_EN,
    output logic [11:0] CSR_W_ADDR,
    output logic [31:0] CSR_W_DATA,
    output logic        FLUSH,
    output logic        JMP_DO,
    output logic [31:0] JMP_PC,
    output logic [1:0]  MODE,
    output logic        INT_ALLOW,
    output logic        BUSY
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [1:0]  MODE_MACHINE = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        W_EPC,
        W_CAUSE,
        W_STATUS,
        JUMP
    } state_t;

    typedef enum logic {
        KIND_TRAP,
        KIND_RET
    } kind_t;

    state_t      state;
    state_t      next_state;
    kind_t       kind;
    logic [31:0] lat_pc;
    logic [31:0] lat_code;
    logic [31:0] lat_jmp;
    logic [31:0] lat_status;
    logic [31:0] lat_epc;
    logic [1:0]  lat_mode;
    logic [1:0]  lat_to;
    logic [1:0]  mode;

    logic        accept_trap;
    logic        accept_ret;
    logic [31:0] status_trap;
    logic [31:0] status_ret;

    // A trap takes priority over a simultaneous mret; the mret is simply dropped.
    assign accept_trap = (state == IDLE) && !MMU_WAIT && TRAP_EN;
    assign accept_ret  = (state == IDLE) && !MMU_WAIT && !TRAP_EN && CHMODE_DO;

    always_comb begin
        status_trap        = lat_status;
        status_trap[7]     = lat_status[3];
        status_trap[3]     = 1'b0;
        status_trap[12:11] = lat_mode;
    end

    always_comb begin
        status_ret         = lat_status;
        status_ret[3]      = lat_status[7];
        status_ret[7]      = 1'b1;
        status_ret[12:11]  = 2'b00;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A stall freezes the sequence in place so the pending action replays on release.
    always_comb begin
        next_state = state;
        if (!MMU_WAIT) begin
            case (state)
                IDLE: begin
                    if (accept_trap) begin
                        next_state = W_EPC;
                    end else if (accept_ret) begin
                        next_state = W_STATUS;
                    end
                end
                W_EPC:    next_state = W_CAUSE;
                W_CAUSE:  next_state = W_STATUS;
                W_STATUS: next_state = JUMP;
                JUMP:     next_state = IDLE;
                default:  next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            kind       <= KIND_TRAP;
            lat_pc     <= 32'h0;
            lat_code   <= 32'h0;
            lat_jmp    <= 32'h0;
            lat_status <= 32'h0;
            lat_epc    <= 32'h0;
            lat_mode   <= 2'b00;
            lat_to     <= 2'b00;
        end else if (accept_trap) begin
            kind       <= KIND_TRAP;
            lat_pc     <= TRAP_PC;
            lat_code   <= TRAP_CODE;
            lat_jmp    <= TRAP_JMP_TO;
            lat_status <= MSTATUS;
            lat_mode   <= mode;
        end else if (accept_ret) begin
            kind       <= KIND_RET;
            lat_epc    <= MEPC;
            lat_status <= MSTATUS;
            lat_to     <= CHMODE_TO;
        end
    end

    // The new privilege mode takes effect only as the redirect cycle completes.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mode <= MODE_RESET;
        end else if ((state == JUMP) && !MMU_WAIT) begin
            mode <= (kind == KIND_TRAP) ? MODE_MACHINE : lat_to;
        end
    end

    always_comb begin
        CSR_W_EN   = 1'b0;
        CSR_W_ADDR = 12'h000;
        CSR_W_DATA = 32'h0;
        FLUSH      = 1'b0;
        JMP_DO     = 1'b0;
        JMP_PC     = 32'h0;
        if (!MMU_WAIT) begin
            case (state)
                W_EPC: begin
                    CSR_W_EN   = 1'b1;
                    CSR_W_ADDR = ADDR_MEPC;
                    CSR_W_DATA = lat_pc;
                end
                W_CAUSE: begin
                    CSR_W_EN   = 1'b1;
                    CSR_W_ADDR = ADDR_MCAUSE;
                    CSR_W_DATA = lat_code;
                end
                W_STATUS: begin
                    CSR_W_EN   = 1'b1;
                    CSR_W_ADDR = ADDR_MSTATUS;
                    CSR_W_DATA = (kind == KIND_TRAP) ? status_trap : status_ret;
                end
                JUMP: begin
                    FLUSH  = 1'b1;
                    JMP_DO = 1'b1;
                    JMP_PC = (kind == KIND_TRAP) ? lat_jmp : lat_epc;
                end
                default: begin
                end
            endcase
        end
    end

    assign MODE      = mode;
    assign BUSY      = (state != IDLE);
    assign INT_ALLOW = MSTATUS[3] && (state == IDLE);

endmodule
